hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter STALL_MAX, default 3: consecutive-stall limit before hazard_err sets.
REQ-002 clk  input  1  the block's single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 id_valid  input  1  the ID stage holds a real instruction.
REQ-005 src1  input  4  Rn index of the instruction in ID.
REQ-006 src2  input  4  Rm/Rd source index of the instruction in ID.
REQ-007 two_src  input  1  the instruction in ID also reads src2.
REQ-008 ex_dest  input  4  dest_out of the ID/EX register.
REQ-009 ex_wb_en  input  1  wb_en_out of the ID/EX register.
REQ-010 ex_mem_read  input  1  mem_read_out of the ID/EX register.
REQ-011 ex_branch_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 freeze  output  1  hold PC and the IF/ID register.
REQ-013 flush_if_id  output  1  bubble the IF/ID register.
REQ-014 flush_id_ex  output  1  bubble the ID/EX register; drives its flush input.
REQ-015 hazard_err  output  1  sticky error: stall run reached STALL_MAX.
REQ-016 stall_cnt  output  16  saturating count of stall cycles.
REQ-017 flush_cnt  output  16  saturating count of taken-branch flushes.

Function
REQ-018 Shadow registers mem_dest_q, mem_wb_en_q SHALL capture ex_dest and ex_wb_en every clk edge, tracking the instruction in MEM.
REQ-019 hit_ex SHALL equal id_valid & ex_wb_en & (ex_dest==src1 | two_src & ex_dest==src2); hit_mem is the same expression using the shadow registers.
REQ-020 stall SHALL be combinational and its source SHALL follow REQ-034/REQ-035.
REQ-021 ex_branch_taken SHALL have priority over stall: freeze = stall & ~ex_branch_taken; flush_if_id = ex_branch_taken; flush_id_ex = stall | ex_branch_taken.
REQ-022 All three control outputs SHALL be combinational, with zero-cycle latency from inputs.
REQ-023 FSM states: RUN, STALL, BRANCH; next state = BRANCH if ex_branch_taken, else STALL if stall, else RUN, from any state.
REQ-024 run_len SHALL load 1 on entry to STALL, increment on STALL->STALL, saturate at STALL_MAX, and clear on entry to any other state.
REQ-025 hazard_err SHALL set when run_len reaches STALL_MAX and remain set until reset.
REQ-026 stall_cnt SHALL increment on each edge where freeze=1 and hold at 16'hFFFF.
REQ-027 flush_cnt SHALL increment on each edge where ex_branch_taken=1 and hold at 16'hFFFF.
REQ-028 Register index 15 (PC) SHALL be compared like any other index; id_valid=0 SHALL suppress every hazard.

Reset
REQ-029 On rst low, the block SHALL immediately enter state RUN.
REQ-030 On rst low, run_len, mem_dest_q, mem_wb_en_q, hazard_err, stall_cnt and flush_cnt SHALL clear to 0.
REQ-031 The combinational outputs SHALL follow REQ-021 during reset, using the cleared shadow values.
REQ-032 A reset asserted mid-stall SHALL drop the stall run; after release, the first edge re-evaluates from RUN.
REQ-033 No output SHALL be registered, so there is no post-reset latency.

Configuration
REQ-034 With FORWARDING_EN defined: stall = hit_ex & ex_mem_read (load-use only, one cycle); the shadow registers SHALL still exist.
REQ-035 Without FORWARDING_EN: stall = hit_ex | hit_mem (up to two stall cycles per dependency).

Structure
REQ-036 The shared pipeline package SHALL hold the FSM state enum, the 4-bit register-index type and the PC index constant 4'd15.
REQ-037 One sub-module SHALL exist, sat_counter16 (increment enable, saturating); it SHALL be instantiated twice, for stall_cnt and flush_cnt.

Verification
REQ-038 Forwarding off: ID src1=3, two_src=0; EX ex_dest=3, ex_wb_en=1 -> freeze=1, flush_id_ex=1 for exactly 2 cycles (EX, then MEM shadow); stall_cnt=2.
REQ-039 FORWARDING_EN: ex_dest=5, ex_wb_en=1, ex_mem_read=1; ID src2=5, two_src=1 -> exactly 1 stall cycle; with ex_mem_read=0 -> no stall.
REQ-040 A stall condition coincides with ex_branch_taken=1 -> freeze=0, flush_if_id=1, flush_id_ex=1; state BRANCH; flush_cnt increments by 1 and stall_cnt is unchanged.
REQ-041 Force hit_ex for 3 consecutive cycles with STALL_MAX=3 -> hazard_err=1 on the 3rd edge and stays 1 after the stimulus is removed; rst low clears it.
REQ-042 Preload stall_cnt to 16'hFFFF, then apply another stall -> holds 16'hFFFF; assert rst mid-stall -> state RUN and all counters 0 immediately.
REQ-043 id_valid=0 with matching indices, or ex_wb_en=0 with matching indices -> no freeze and no flush.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared pipeline types for the hazard unit.
//   hz_state_e - hazard FSM state (RUN / STALL / BRANCH)
//   reg_idx_t  - 4-bit architectural register index
//   PC_IDX     - index of the PC (r15); compared like any other register
//   src_hit()  - dependency match of an ID-stage instruction against one
//                in-flight writer
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_BRANCH = 2'd2
  } hz_state_e;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t PC_IDX = 4'd15;

  function automatic logic src_hit(
    input logic     id_valid,
    input logic     wb_en,
    input reg_idx_t dest,
    input reg_idx_t src1,
    input reg_idx_t src2,
    input logic     two_src
  );
    return id_valid & wb_en & ((dest == src1) | (two_src & (dest == src2)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: ID/EX hazard signals between the pipeline and the hazard unit.
//   master - pipeline side: drives ID/EX status, receives control/counters
//   slave  - hazard unit side
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic        id_valid;
  reg_idx_t    src1;
  reg_idx_t    src2;
  logic        two_src;
  reg_idx_t    ex_dest;
  logic        ex_wb_en;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        freeze;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        hazard_err;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_valid, src1, src2, two_src, ex_dest, ex_wb_en, ex_mem_read,
           ex_branch_taken,
    input  freeze, flush_if_id, flush_id_ex, hazard_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, src1, src2, two_src, ex_dest, ex_wb_en, ex_mem_read,
           ex_branch_taken,
    output freeze, flush_if_id, flush_id_ex, hazard_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at 16'hFFFF.
//   clk - clock, rst - async active-low reset
//   inc - count this edge
//   cnt - current count
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: data-hazard stall / branch-flush control for a 5-stage pipe.
//   clk, rst  - clock, async active-low reset
//   hif       - hazard_unit_if.slave: ID sources, ID/EX status, control
//               outputs (freeze, flush_if_id, flush_id_ex), sticky
//               hazard_err, saturating stall_cnt / flush_cnt
//   STALL_MAX - consecutive stall cycles that raise hazard_err
// Build option FORWARDING_EN: only load-use hazards against EX stall;
// otherwise any dependency on EX or MEM stalls.
// Control outputs are purely combinational; only bookkeeping is registered.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int STALL_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hif
);
  localparam int RW = $clog2(STALL_MAX + 1);

  hz_state_e       state_q, state_d;
  logic [RW-1:0]   run_len_q, run_len_d;
  reg_idx_t        mem_dest_q, mem_dest_d;
  logic            mem_wb_en_q, mem_wb_en_d;
  logic            hazard_err_q, hazard_err_d;
  logic            hit_ex, hit_mem, stall;
  logic            freeze, flush_if_id, flush_id_ex;

  assign hit_ex  = src_hit(hif.id_valid, hif.ex_wb_en, hif.ex_dest,
                           hif.src1, hif.src2, hif.two_src);
  assign hit_mem = src_hit(hif.id_valid, mem_wb_en_q, mem_dest_q,
                           hif.src1, hif.src2, hif.two_src);

`ifdef FORWARDING_EN
  // MEM results are forwarded; only a load in EX cannot be.
  assign stall = hit_ex & hif.ex_mem_read;
  logic unused_hit_mem;
  assign unused_hit_mem = hit_mem;
`else
  assign stall = hit_ex | hit_mem;
  logic unused_mem_read;
  assign unused_mem_read = hif.ex_mem_read;
`endif

  // Shadow of the ID/EX destination: the instruction now moving into MEM.
  assign mem_dest_d  = hif.ex_dest;
  assign mem_wb_en_d = hif.ex_wb_en;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      run_len_q    <= '0;
      mem_dest_q   <= '0;
      mem_wb_en_q  <= 1'b0;
      hazard_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_len_q    <= run_len_d;
      mem_dest_q   <= mem_dest_d;
      mem_wb_en_q  <= mem_wb_en_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  // Next-state: same decision from every state; branch wins.
  always_comb begin
    state_d = ST_RUN;
    if (hif.ex_branch_taken) state_d = ST_BRANCH;
    else if (stall)          state_d = ST_STALL;

    run_len_d = '0;
    if (state_d == ST_STALL) begin
      if (state_q != ST_STALL)                 run_len_d = RW'(1);
      else if (run_len_q < RW'(STALL_MAX))     run_len_d = run_len_q + RW'(1);
      else                                     run_len_d = run_len_q;
    end

    // Looking at run_len_d sets the error on the edge the run hits the limit.
    hazard_err_d = hazard_err_q | (run_len_d == RW'(STALL_MAX));
  end

  // Outputs: branch overrides stall so the squashed instruction is not held.
  always_comb begin
    freeze      = stall & ~hif.ex_branch_taken;
    flush_if_id = hif.ex_branch_taken;
    flush_id_ex = stall | hif.ex_branch_taken;
  end

  assign hif.freeze      = freeze;
  assign hif.flush_if_id = flush_if_id;
  assign hif.flush_id_ex = flush_id_ex;
  assign hif.hazard_err  = hazard_err_q;

  sat_counter16 u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze),
    .cnt (hif.stall_cnt)
  );

  sat_counter16 u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hif.ex_branch_taken),
    .cnt (hif.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_unit_if hif ();

  hazard_unit #(.STALL_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  task automatic idle();
    hif.id_valid = 1'b0; hif.src1 = '0; hif.src2 = '0; hif.two_src = 1'b0;
    hif.ex_dest = '0; hif.ex_wb_en = 1'b0; hif.ex_mem_read = 1'b0;
    hif.ex_branch_taken = 1'b0;
  endtask

  // Load in EX writing r7, ID reads r7: stalls in either build.
  task automatic drive_load_use();
    hif.id_valid = 1'b1; hif.src1 = 4'd7; hif.src2 = 4'd0; hif.two_src = 1'b0;
    hif.ex_dest = 4'd7; hif.ex_wb_en = 1'b1; hif.ex_mem_read = 1'b1;
    hif.ex_branch_taken = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b0 || hif.flush_id_ex !== 1'b0 || hif.flush_if_id !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got %b%b%b want 000", hif.freeze, hif.flush_if_id, hif.flush_id_ex); end
    checks++; if (hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0 || hif.hazard_err !== 1'b0) begin
      errors++; $display("FAIL reset_cnt got %h %h %b want 0 0 0", hif.stall_cnt, hif.flush_cnt, hif.hazard_err); end
    checks++; if (dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL reset_state got %0d want %0d", dut.state_q, ST_RUN); end
    // Control stays combinational while reset is held.
    drive_load_use();
    #1;
    checks++; if (hif.freeze !== 1'b1 || hif.flush_id_ex !== 1'b1) begin
      errors++; $display("FAIL reset_comb got f=%b fx=%b want 1 1", hif.freeze, hif.flush_id_ex); end
    edge1();
    checks++; if (hif.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_hold_cnt got %h want 0", hif.stall_cnt); end
    idle();
    @(negedge clk); rst = 1'b1;
    #1;
  endtask

`ifdef FORWARDING_EN
  task automatic test_stall();
    do_reset();
    hif.id_valid = 1'b1; hif.src1 = 4'd0; hif.src2 = 4'd5; hif.two_src = 1'b1;
    hif.ex_dest = 4'd5; hif.ex_wb_en = 1'b1; hif.ex_mem_read = 1'b1;
    #1;
    checks++; if (hif.freeze !== 1'b1 || hif.flush_id_ex !== 1'b1) begin
      errors++; $display("FAIL fwd_stall got f=%b fx=%b want 1 1", hif.freeze, hif.flush_id_ex); end
    edge1();
    hif.ex_wb_en = 1'b0; hif.ex_mem_read = 1'b0; hif.ex_dest = 4'd0;
    #1;
    checks++; if (hif.freeze !== 1'b0) begin
      errors++; $display("FAIL fwd_one_cycle got %b want 0", hif.freeze); end
    edge1();
    checks++; if (hif.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL fwd_stall_cnt got %0d want 1", hif.stall_cnt); end
    hif.ex_dest = 4'd5; hif.ex_wb_en = 1'b1; hif.ex_mem_read = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b0 || hif.flush_id_ex !== 1'b0) begin
      errors++; $display("FAIL fwd_no_load got f=%b fx=%b want 0 0", hif.freeze, hif.flush_id_ex); end
    idle();
  endtask
`else
  task automatic test_stall();
    do_reset();
    hif.id_valid = 1'b1; hif.src1 = 4'd3; hif.two_src = 1'b0;
    hif.ex_dest = 4'd3; hif.ex_wb_en = 1'b1; hif.ex_mem_read = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b1 || hif.flush_id_ex !== 1'b1 || hif.flush_if_id !== 1'b0) begin
      errors++; $display("FAIL stall_ex got %b%b%b want 101", hif.freeze, hif.flush_if_id, hif.flush_id_ex); end
    edge1();
    // EX now holds the bubble; the producer sits in MEM.
    hif.ex_dest = 4'd0; hif.ex_wb_en = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b1 || dut.state_q !== ST_STALL) begin
      errors++; $display("FAIL stall_mem got f=%b st=%0d want 1 %0d", hif.freeze, dut.state_q, ST_STALL); end
    edge1();
    checks++; if (hif.freeze !== 1'b0 || hif.flush_id_ex !== 1'b0) begin
      errors++; $display("FAIL stall_release got f=%b fx=%b want 0 0", hif.freeze, hif.flush_id_ex); end
    checks++; if (hif.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_cnt got %0d want 2", hif.stall_cnt); end
    edge1();
    checks++; if (dut.state_q !== ST_RUN || hif.stall_cnt !== 16'd2) begin
      errors++; $display("FAIL stall_end got st=%0d cnt=%0d want %0d 2", dut.state_q, hif.stall_cnt, ST_RUN); end
    idle();
  endtask
`endif

  task automatic test_sources();
    do_reset();
    drive_load_use();
    hif.src1 = 4'd1; hif.src2 = 4'd7; hif.two_src = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b0) begin
      errors++; $display("FAIL src2_ignored got %b want 0", hif.freeze); end
    hif.two_src = 1'b1;
    #1;
    checks++; if (hif.freeze !== 1'b1) begin
      errors++; $display("FAIL src2_used got %b want 1", hif.freeze); end
    hif.ex_dest = PC_IDX; hif.src1 = PC_IDX; hif.src2 = 4'd2;
    #1;
    checks++; if (hif.freeze !== 1'b1) begin
      errors++; $display("FAIL pc_index got %b want 1", hif.freeze); end
    idle();
  endtask

  task automatic test_suppress();
    do_reset();
    drive_load_use();
    hif.id_valid = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b0 || hif.flush_id_ex !== 1'b0 || hif.flush_if_id !== 1'b0) begin
      errors++; $display("FAIL no_id_valid got %b%b%b want 000", hif.freeze, hif.flush_if_id, hif.flush_id_ex); end
    hif.id_valid = 1'b1; hif.ex_wb_en = 1'b0;
    #1;
    checks++; if (hif.freeze !== 1'b0 || hif.flush_id_ex !== 1'b0 || hif.flush_if_id !== 1'b0) begin
      errors++; $display("FAIL no_wb_en got %b%b%b want 000", hif.freeze, hif.flush_if_id, hif.flush_id_ex); end
    edge1();
    checks++; if (hif.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL suppress_cnt got %0d want 0", hif.stall_cnt); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    drive_load_use();
    hif.ex_branch_taken = 1'b1;
    #1;
    checks++; if (hif.freeze !== 1'b0 || hif.flush_if_id !== 1'b1 || hif.flush_id_ex !== 1'b1) begin
      errors++; $display("FAIL branch_ctrl got %b%b%b want 011", hif.freeze, hif.flush_if_id, hif.flush_id_ex); end
    edge1();
    checks++; if (dut.state_q !== ST_BRANCH) begin
      errors++; $display("FAIL branch_state got %0d want %0d", dut.state_q, ST_BRANCH); end
    checks++; if (hif.flush_cnt !== 16'd1 || hif.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL branch_cnt got fl=%0d st=%0d want 1 0", hif.flush_cnt, hif.stall_cnt); end
    idle();
    edge1();
    checks++; if (dut.state_q !== ST_RUN || hif.flush_cnt !== 16'd1) begin
      errors++; $display("FAIL branch_exit got st=%0d fl=%0d want %0d 1", dut.state_q, hif.flush_cnt, ST_RUN); end
  endtask

  task automatic test_hazard_err();
    do_reset();
    drive_load_use();
    edge1();
    edge1();
    checks++; if (hif.hazard_err !== 1'b0) begin
      errors++; $display("FAIL err_early got %b want 0", hif.hazard_err); end
    edge1();
    checks++; if (hif.hazard_err !== 1'b1) begin
      errors++; $display("FAIL err_set got %b want 1", hif.hazard_err); end
    idle();
    edge1();
    edge1();
    checks++; if (hif.hazard_err !== 1'b1 || dut.state_q !== ST_RUN) begin
      errors++; $display("FAIL err_sticky got %b st=%0d want 1 %0d", hif.hazard_err, dut.state_q, ST_RUN); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (hif.hazard_err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", hif.hazard_err); end
    @(negedge clk); rst = 1'b1; #1;
  endtask

  task automatic test_saturate();
    do_reset();
    drive_load_use();
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (hif.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %h want ffff", hif.stall_cnt); end
    edge1();
    edge1();
    checks++; if (hif.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h want ffff", hif.stall_cnt); end
    // Reset mid-stall, stall still being driven.
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (dut.state_q !== ST_RUN || hif.stall_cnt !== 16'd0 || hif.flush_cnt !== 16'd0 || hif.hazard_err !== 1'b0) begin
      errors++; $display("FAIL sat_rst got st=%0d sc=%h fc=%h err=%b want %0d 0 0 0",
                         dut.state_q, hif.stall_cnt, hif.flush_cnt, hif.hazard_err, ST_RUN); end
    @(negedge clk); rst = 1'b1;
    edge1();
    checks++; if (dut.state_q !== ST_STALL || hif.stall_cnt !== 16'd1 || hif.hazard_err !== 1'b0) begin
      errors++; $display("FAIL post_rst got st=%0d sc=%0d err=%b want %0d 1 0",
                         dut.state_q, hif.stall_cnt, hif.hazard_err, ST_STALL); end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_stall();
    test_sources();
    test_suppress();
    test_branch();
    test_hazard_err();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
